// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 convolutional code (generators 7, 5 octal).
// Used by both conv_encoder and the Viterbi decoder so the two always agree on the
// generator taps, the symbol packing order and the encoder FSM encoding.
package viterbi_pkg;

   localparam int unsigned K = 3;

   // Generator taps, MSB applies to the current bit, LSB to the oldest state bit.
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   typedef enum logic [1:0] {
      S_DATA,
      S_TAIL1,
      S_TAIL2
   } enc_state_e;

   // Symbol packing order on the wire: {g0, g1}.
   function automatic logic [1:0] pack_sym(input logic g0, input logic g1);
      return {g0, g1};
   endfunction

endpackage

// File: rtl/enc_branch.sv
// One trellis branch of the K=3 encoder: given the input bit and the current state
// {s1, s0}, produce the coded symbol and the next state. Purely combinational.
// Ports:
//   b          - information bit
//   s1, s0     - current trellis state (s1 = previous bit, s0 = the bit before it)
//   sym        - coded symbol, packed {g0, g1}
//   next_state - trellis state after this bit, {b, s1}
module enc_branch
   import viterbi_pkg::*;
(
   input  logic       b,
   input  logic       s1,
   input  logic       s0,
   output logic [1:0] sym,
   output logic [1:0] next_state
);

   logic [K-1:0] window;

   always_comb begin
      window     = {b, s1, s0};
      sym        = pack_sym(^(window & G0), ^(window & G1));
      next_state = {b, s1};
   end

endmodule

// File: rtl/conv_encoder.sv
// Streaming K=3 rate-1/2 convolutional encoder with zero-tail termination.
// Each frame of N information bits yields N+2 symbols; the last symbol carries out_last.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - input handshake; in_bit is the data, in_last ends a frame
//   out_valid/out_ready  - output handshake; out_sym = {g0, g1}, out_last on 2nd tail symbol
//   frame_cnt            - number of completed frames, wraps modulo 2^CNT_W
module conv_encoder
   import viterbi_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_sym,
   output logic             out_last,
   output logic [CNT_W-1:0] frame_cnt
);

   enc_state_e       state_q;
   logic [1:0]       trellis_q;
   logic             out_valid_q;
   logic [1:0]       out_sym_q;
   logic             out_last_q;
   logic [CNT_W-1:0] frame_cnt_q;

   logic             slot_free;
   logic             branch_b;
   logic [1:0]       branch_sym;
   logic [1:0]       branch_next;

   // The output register can take a new symbol when empty or being drained this cycle.
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = (state_q == S_DATA) && slot_free;

   // Tail states flush the trellis with zeros.
   assign branch_b = (state_q == S_DATA) ? in_bit : 1'b0;

   enc_branch u_branch (
      .b          (branch_b),
      .s1         (trellis_q[1]),
      .s0         (trellis_q[0]),
      .sym        (branch_sym),
      .next_state (branch_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_DATA;
         trellis_q   <= 2'b00;
         out_valid_q <= 1'b0;
         out_sym_q   <= 2'b00;
         out_last_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else if (slot_free) begin
         // Under backpressure nothing changes, so all updates sit behind slot_free.
         unique case (state_q)
            S_DATA: begin
               if (in_valid) begin
                  out_sym_q   <= branch_sym;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
                  trellis_q   <= branch_next;
                  if (in_last) state_q <= S_TAIL1;
               end else begin
                  out_valid_q <= 1'b0;
               end
            end
            S_TAIL1: begin
               out_sym_q   <= branch_sym;
               out_valid_q <= 1'b1;
               out_last_q  <= 1'b0;
               trellis_q   <= branch_next;
               state_q     <= S_TAIL2;
            end
            S_TAIL2: begin
               out_sym_q   <= branch_sym;
               out_valid_q <= 1'b1;
               out_last_q  <= 1'b1;
               trellis_q   <= 2'b00;
               frame_cnt_q <= frame_cnt_q + CNT_W'(1);
               state_q     <= S_DATA;
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_DATA;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_last  = out_last_q;
   assign frame_cnt = frame_cnt_q;

endmodule
